// File: rtl/dht11_pkg.sv
// Shared constants, FSM encoding and BCD helper for the DHT11 polling block.
package dht11_pkg;

    // Defaults at a 50 MHz system clock: 2 s between requests, 30 ms to answer.
    localparam int unsigned DEF_POLL_CYCLES    = 100_000_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_500_000;

    // Plausibility limits for the integer bytes reported by the sensor.
    localparam logic [7:0] TEMP_MAX = 8'd50;
    localparam logic [7:0] HUM_MAX  = 8'd99;

    // One shift per input bit of the binary-to-BCD converter.
    localparam int unsigned BCD_ITER = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_REQ         = 3'd1,
        ST_WAIT_DONE   = 3'd2,
        ST_CONVERT     = 3'd3,
        ST_UPDATE      = 3'd4,
        ST_WAIT_PERIOD = 3'd5
    } state_t;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more,
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [11:0] bcd_add3(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// start loads the operand; eight shift cycles later done pulses for one cycle
// and bcd holds the result until the next start.
module bin2bcd8
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] adj;

    // Load on start, otherwise run one correct-and-shift step per busy cycle.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj    = bcd_add3(sh_q[19:8]);
        if (start) begin
            sh_d   = {12'd0, bin};
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = {adj[10:0], sh_q[7:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(BCD_ITER - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sh_q[19:8];

endmodule

// File: rtl/dht11_poll.sv
// Periodic DHT11 poller: issues a request every POLL_CYCLES while enabled,
// validates the answer, converts temperature and humidity to BCD and reports
// accepted samples; rejected answers and timeouts bump a saturating counter.
module dht11_poll
    import dht11_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = DEF_POLL_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        enable,
    output logic        dht11_req,
    input  logic        dht11_done,
    input  logic        dht11_error,
    input  logic [7:0]  tempH,
    input  logic [7:0]  tempL,
    input  logic [7:0]  humidityH,
    input  logic [7:0]  humidityL,
    output logic [7:0]  temp_int,
    output logic [7:0]  hum_int,
    output logic [11:0] temp_bcd,
    output logic [11:0] hum_bcd,
    output logic        data_valid,
    output logic        sample_stb,
    output logic        timeout_stb,
    output logic [7:0]  fail_cnt
);

    state_t            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;
    logic [1:0][7:0]   cap_q, cap_d;        // [0] temperature, [1] humidity
    logic [7:0]        temp_int_q, temp_int_d;
    logic [7:0]        hum_int_q, hum_int_d;
    logic [11:0]       temp_bcd_q, temp_bcd_d;
    logic [11:0]       hum_bcd_q, hum_bcd_d;
    logic              data_valid_q, data_valid_d;

    logic              sample_good;
    logic              timeout_hit;
    logic              poll_due;
    logic              conv_start;
    logic              conv_done;
    logic              conv_busy;
    logic [1:0]        conv_busy_w;
    logic [1:0]        conv_done_w;
    logic [1:0][11:0]  conv_bcd;

    // The DHT11 fractional bytes are always zero and carry no information.
    logic              unused_frac;
    assign unused_frac = ^{tempL, humidityL};

    assign sample_good = dht11_done && !dht11_error &&
                         (tempH <= TEMP_MAX) && (humidityH <= HUM_MAX);
    // period_q counts cycles since the last request (1 in the cycle after REQ).
    assign timeout_hit = (period_q >= TIMEOUT_CYCLES);
    assign poll_due    = (period_q >= POLL_CYCLES - 1);
    assign conv_done   = &conv_done_w;
    assign conv_busy   = |conv_busy_w;

    // Temperature and humidity converters run in lockstep from the captured bytes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_conv
            bin2bcd8 u_bcd (
                .clk   (sys_clk),
                .rst   (rst),
                .start (conv_start),
                .bin   (cap_q[gi]),
                .busy  (conv_busy_w[gi]),
                .done  (conv_done_w[gi]),
                .bcd   (conv_bcd[gi])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a done pulse beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:        if (enable) state_d = ST_REQ;
            ST_REQ:         state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (dht11_done) begin
                    state_d = sample_good ? ST_CONVERT : ST_WAIT_PERIOD;
                end else if (timeout_hit) begin
                    state_d = ST_WAIT_PERIOD;
                end
            end
            ST_CONVERT:     if (conv_done) state_d = ST_UPDATE;
            ST_UPDATE:      state_d = ST_WAIT_PERIOD;
            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (poll_due) begin
                    state_d = ST_REQ;
                end
            end
            default:        state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: strobes and the converter kick (first CONVERT cycle only).
    always_comb begin
        dht11_req   = (state_q == ST_REQ);
        sample_stb  = (state_q == ST_UPDATE);
        timeout_stb = (state_q == ST_WAIT_DONE) && !dht11_done && timeout_hit;
        conv_start  = (state_q == ST_CONVERT) && !conv_busy && !conv_done;
    end

    // Datapath next values: period counter, failure counter, capture and results.
    always_comb begin
        period_d     = period_q;
        fail_cnt_d   = fail_cnt_q;
        cap_d        = cap_q;
        temp_int_d   = temp_int_q;
        hum_int_d    = hum_int_q;
        temp_bcd_d   = temp_bcd_q;
        hum_bcd_d    = hum_bcd_q;
        data_valid_d = data_valid_q;

        if (state_q == ST_IDLE) begin
            period_d = '0;
        end else if (state_q == ST_REQ) begin
            period_d = 32'd1;
        end else if (period_q != '1) begin
            period_d = period_q + 32'd1;
        end

        if (state_q == ST_WAIT_DONE) begin
            if (sample_good) begin
                cap_d[0] = tempH;
                cap_d[1] = humidityH;
            end
            if (((dht11_done && !sample_good) || (!dht11_done && timeout_hit)) &&
                (fail_cnt_q != 8'hFF)) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
        end

        // Results load on entry to UPDATE so they are valid alongside sample_stb.
        if ((state_q == ST_CONVERT) && conv_done) begin
            temp_int_d   = cap_q[0];
            hum_int_d    = cap_q[1];
            temp_bcd_d   = conv_bcd[0];
            hum_bcd_d    = conv_bcd[1];
            data_valid_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            period_q     <= '0;
            fail_cnt_q   <= '0;
            cap_q        <= '0;
            temp_int_q   <= '0;
            hum_int_q    <= '0;
            temp_bcd_q   <= '0;
            hum_bcd_q    <= '0;
            data_valid_q <= 1'b0;
        end else begin
            period_q     <= period_d;
            fail_cnt_q   <= fail_cnt_d;
            cap_q        <= cap_d;
            temp_int_q   <= temp_int_d;
            hum_int_q    <= hum_int_d;
            temp_bcd_q   <= temp_bcd_d;
            hum_bcd_q    <= hum_bcd_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign temp_int   = temp_int_q;
    assign hum_int    = hum_int_q;
    assign temp_bcd   = temp_bcd_q;
    assign hum_bcd    = hum_bcd_q;
    assign data_valid = data_valid_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_dht11_poll.sv
// Directed bench for dht11_poll (POLL_CYCLES=1000, TIMEOUT_CYCLES=200) plus a
// short-period second instance used to drive the failure counter into saturation.
module tb_dht11_poll;

    localparam int POLL = 1000;
    localparam int TMO  = 200;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst, enable, dht11_done, dht11_error;
    logic [7:0]  tempH, tempL, humidityH, humidityL;
    logic        dht11_req, data_valid, sample_stb, timeout_stb;
    logic [7:0]  temp_int, hum_int, fail_cnt;
    logic [11:0] temp_bcd, hum_bcd;

    logic        sat_rst, sat_enable;
    logic        sat_req, sat_valid, sat_stb, sat_to_stb;
    logic [7:0]  sat_tint, sat_hint, sat_fail;
    logic [11:0] sat_tbcd, sat_hbcd;

    dht11_poll #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) u_dut (
        .sys_clk(sys_clk), .rst(rst), .enable(enable), .dht11_req(dht11_req),
        .dht11_done(dht11_done), .dht11_error(dht11_error),
        .tempH(tempH), .tempL(tempL), .humidityH(humidityH), .humidityL(humidityL),
        .temp_int(temp_int), .hum_int(hum_int), .temp_bcd(temp_bcd), .hum_bcd(hum_bcd),
        .data_valid(data_valid), .sample_stb(sample_stb), .timeout_stb(timeout_stb),
        .fail_cnt(fail_cnt)
    );

    dht11_poll #(.POLL_CYCLES(20), .TIMEOUT_CYCLES(8)) u_sat (
        .sys_clk(sys_clk), .rst(sat_rst), .enable(sat_enable), .dht11_req(sat_req),
        .dht11_done(1'b0), .dht11_error(1'b0),
        .tempH(8'd0), .tempL(8'd0), .humidityH(8'd0), .humidityL(8'd0),
        .temp_int(sat_tint), .hum_int(sat_hint), .temp_bcd(sat_tbcd), .hum_bcd(sat_hbcd),
        .data_valid(sat_valid), .sample_stb(sat_stb), .timeout_stb(sat_to_stb),
        .fail_cnt(sat_fail)
    );

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int req_count = 0, stb_count = 0, to_count = 0, sat_to = 0;
    int last_req = -1, last_stb = -1, last_to = -1;
    int req_log[$];

    // Observe outputs late in each cycle, well after inputs change at negedge.
    always @(negedge sys_clk) begin
        #4;
        if (dht11_req) begin
            req_count++; last_req = cyc; req_log.push_back(cyc);
        end
        if (sample_stb) begin
            stb_count++; last_stb = cyc;
            $display("[cyc %0d] sample temp_bcd=%03h hum_bcd=%03h fail_cnt=%0d", cyc, temp_bcd, hum_bcd, fail_cnt);
        end
        if (timeout_stb) begin
            to_count++; last_to = cyc;
            $display("[cyc %0d] timeout fail_cnt=%0d", cyc, fail_cnt);
        end
        if (sat_to_stb) sat_to++;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic wait_req(input string tag, output int rc);
        int base = req_count;
        int k = 0;
        while (req_count == base && k < 2500) begin tick(); k++; end
        if (req_count == base) check(tag, 32'(req_count - base), 32'd1);
        rc = last_req;
    endtask

    task automatic wait_stb(input string tag, output int sc);
        int base = stb_count;
        int k = 0;
        while (stb_count == base && k < 300) begin tick(); k++; end
        if (stb_count == base) check(tag, 32'(stb_count - base), 32'd1);
        sc = last_stb;
    endtask

    task automatic wait_to(input string tag, output int tc);
        int base = to_count;
        int k = 0;
        while (to_count == base && k < 1500) begin tick(); k++; end
        if (to_count == base) check(tag, 32'(to_count - base), 32'd1);
        tc = last_to;
    endtask

    // Done pulse driven for one cycle; sampled at the following rising edge.
    task automatic pulse_done(input logic err, input logic [7:0] t, input logic [7:0] h);
        dht11_done = 1'b1; dht11_error = err;
        tempH = t; humidityH = h; tempL = 8'h05; humidityL = 8'h07;
        tick();
        dht11_done = 1'b0; dht11_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; dht11_done = 1'b0; dht11_error = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int r, r2, r3, s, t, c0, sb, tb0, rq;

    initial begin
        rst = 1'b1; sat_rst = 1'b1; enable = 1'b0; sat_enable = 1'b0;
        dht11_done = 1'b0; dht11_error = 1'b0;
        tempH = '0; tempL = '0; humidityH = '0; humidityL = '0;
        repeat (3) tick();

        // Reset state
        check("rst_req",      32'(dht11_req),   32'd0);
        check("rst_temp_int", 32'(temp_int),    32'd0);
        check("rst_hum_int",  32'(hum_int),     32'd0);
        check("rst_temp_bcd", 32'(temp_bcd),    32'd0);
        check("rst_hum_bcd",  32'(hum_bcd),     32'd0);
        check("rst_valid",    32'(data_valid),  32'd0);
        check("rst_stb",      32'(sample_stb),  32'd0);
        check("rst_to_stb",   32'(timeout_stb), 32'd0);
        check("rst_fail",     32'(fail_cnt),    32'd0);
        rst = 1'b0; sat_rst = 1'b0; sat_enable = 1'b1;
        tick();

        // Good sample: done 50 cycles after req, sample_stb 10 cycles after sampling edge
        enable = 1'b1; c0 = cyc;
        wait_req("s1_req_timeout", r);
        check("s1_req_first", 32'(r), 32'(c0 + 1));
        wait_until(r + 50);
        pulse_done(1'b0, 8'd25, 8'd60);
        wait_stb("s1_stb_timeout", s);
        check("s1_latency", 32'(s), 32'(r + 61));
        check("s1_temp_bcd", 32'(temp_bcd), 32'h025);
        check("s1_hum_bcd",  32'(hum_bcd),  32'h060);
        check("s1_temp_int", 32'(temp_int), 32'd25);
        check("s1_hum_int",  32'(hum_int),  32'd60);
        check("s1_valid",    32'(data_valid), 32'd1);
        check("s1_fail",     32'(fail_cnt), 32'd0);

        // Timeout: no answer, outputs held, spacing unaffected
        sb = stb_count;
        wait_req("s3_req_timeout", r2);
        check("s3_spacing", 32'(r2 - r), 32'(POLL));
        wait_to("s3_to_timeout", t);
        check("s3_to_delay", 32'(t - r2), 32'(TMO));
        tick();
        check("s3_fail", 32'(fail_cnt), 32'd1);
        check("s3_temp_held", 32'(temp_bcd), 32'h025);
        check("s3_valid_held", 32'(data_valid), 32'd1);
        check("s3_no_stb", 32'(stb_count - sb), 32'd0);
        wait_req("s3_next_timeout", r3);
        check("s3_next_spacing", 32'(r3 - r2), 32'(POLL));

        // Periodic spacing over 3500 cycles
        do_reset();
        req_log.delete();
        enable = 1'b1; c0 = cyc;
        wait_until(c0 + 3500);
        enable = 1'b0;
        check("s2_req_total", 32'(req_log.size()), 32'd4);
        for (int i = 1; i < req_log.size(); i++)
            check("s2_spacing", 32'(req_log[i] - req_log[i-1]), 32'(POLL));
        check("s2_fail", 32'(fail_cnt), 32'd4);

        // Rejections, ignored stray done, range boundaries
        do_reset();
        sb = stb_count;
        enable = 1'b1;
        wait_req("s4_req1", r);
        wait_until(r + 30); pulse_done(1'b1, 8'd20, 8'd40); tick();
        check("s4_err_fail", 32'(fail_cnt), 32'd1);
        wait_until(r + 300); pulse_done(1'b0, 8'd30, 8'd40); tick();
        check("s4_stray_fail", 32'(fail_cnt), 32'd1);
        wait_req("s4_req2", r);
        wait_until(r + 30); pulse_done(1'b0, 8'd20, 8'd120); tick();
        check("s4_hum120_fail", 32'(fail_cnt), 32'd2);
        wait_req("s4_req3", r);
        wait_until(r + 30); pulse_done(1'b0, 8'd99, 8'd50); tick();
        check("s4_temp99_fail", 32'(fail_cnt), 32'd3);
        wait_req("s4_req4", r);
        wait_until(r + 30); pulse_done(1'b0, 8'd51, 8'd50); tick();
        check("s4_temp51_fail", 32'(fail_cnt), 32'd4);
        check("s4_no_stb", 32'(stb_count - sb), 32'd0);
        check("s4_not_valid", 32'(data_valid), 32'd0);
        wait_req("s4_req5", r);
        wait_until(r + 30); pulse_done(1'b0, 8'd50, 8'd99);
        wait_stb("s4_edge_stb", s);
        check("s4_edge_temp", 32'(temp_bcd), 32'h050);
        check("s4_edge_hum",  32'(hum_bcd),  32'h099);
        check("s4_edge_fail", 32'(fail_cnt), 32'd4);

        // Done on the timeout cycle is accepted without timeout_stb
        tb0 = to_count;
        wait_req("s5_req", r);
        wait_until(r + TMO); pulse_done(1'b0, 8'd33, 8'd44);
        wait_stb("s5_stb", s);
        check("s5_latency", 32'(s), 32'(r + TMO + 11));
        check("s5_no_to", 32'(to_count - tb0), 32'd0);
        check("s5_fail", 32'(fail_cnt), 32'd4);
        check("s5_temp", 32'(temp_bcd), 32'h033);
        check("s5_hum",  32'(hum_bcd),  32'h044);

        // Reset during CONVERT aborts, then polling restarts from IDLE
        wait_req("s6_req", r);
        wait_until(r + 50); pulse_done(1'b0, 8'd12, 8'd34); tick();
        sb = stb_count;
        rst = 1'b1; tick();
        check("s6_temp_int", 32'(temp_int), 32'd0);
        check("s6_hum_int",  32'(hum_int),  32'd0);
        check("s6_temp_bcd", 32'(temp_bcd), 32'd0);
        check("s6_hum_bcd",  32'(hum_bcd),  32'd0);
        check("s6_valid",    32'(data_valid), 32'd0);
        check("s6_fail",     32'(fail_cnt), 32'd0);
        tick();
        rst = 1'b0; c0 = cyc;
        wait_req("s6_restart", r);
        check("s6_restart_cyc", 32'(r), 32'(c0 + 1));
        wait_until(r + 40);
        check("s6_no_stb", 32'(stb_count - sb), 32'd0);

        // Enable dropped in WAIT_DONE: sample still reported, then no more requests
        do_reset();
        enable = 1'b1;
        wait_req("s7_req", r);
        wait_until(r + 20); enable = 1'b0;
        wait_until(r + 50); pulse_done(1'b0, 8'd18, 8'd55);
        wait_stb("s7_stb", s);
        check("s7_latency", 32'(s), 32'(r + 61));
        check("s7_temp", 32'(temp_bcd), 32'h018);
        check("s7_hum",  32'(hum_bcd),  32'h055);
        rq = req_count;
        wait_until(r + 2100);
        check("s7_no_req", 32'(req_count - rq), 32'd0);

        // Saturation on the short-period instance (>= 300 timeouts by now)
        check("sat_enough_to", 32'(sat_to >= 300), 32'd1);
        check("sat_fail_255", 32'(sat_fail), 32'd255);
        check("sat_no_valid", 32'(sat_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
